// File: rtl/contador_ud_pulsos_pkg.sv
// -----------------------------------------------------------------------------
// contador_ud_pulsos_pkg
// Shared constants for the up/down pulse counter and the display stage that
// consumes its count.
//   - mode_e     : behaviour at the count limits (wrap or saturate)
//   - op_e       : decoded per-cycle action of the counter
//   - DEF_WIDTH  : default counter width
//   - DEF_LIMIT  : default upper count limit
// -----------------------------------------------------------------------------
package contador_ud_pulsos_pkg;

    // iSat encoding: 0 = wrap around at the limits, 1 = stick at the limits
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // What the counter does in a given cycle, after priority resolution
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LIMIT = 255;

endpackage : contador_ud_pulsos_pkg

// File: rtl/contador_ud_pulsos.sv
// -----------------------------------------------------------------------------
// contador_ud_pulsos
// Up/down counter driven by single-cycle increment/decrement pulses (one
// positive-edge detector per push-button upstream). The count runs from 0 to
// LIMIT, with selectable wrap/saturate behaviour at both ends, a clamped
// synchronous load, and one-cycle overflow/underflow strobes.
//
// Parameters
//   WIDTH  : counter width in bits
//   LIMIT  : maximum count value (1 .. 2^WIDTH-1); minimum is always 0
//
// Ports
//   iClk    in   system clock, rising edge
//   iReset  in   synchronous active-high reset (highest priority)
//   iInc    in   increment pulse
//   iDec    in   decrement pulse
//   iLoad   in   synchronous load strobe (beats iInc/iDec)
//   iData   in   load value, clamped to LIMIT
//   iSat    in   0 = wrap at limits, 1 = saturate at limits
//   oCount  out  registered count
//   oAtMax  out  oCount == LIMIT
//   oAtMin  out  oCount == 0
//   oOvf    out  one-cycle strobe: increment attempted at LIMIT
//   oUnf    out  one-cycle strobe: decrement attempted at 0
// -----------------------------------------------------------------------------
module contador_ud_pulsos
    import contador_ud_pulsos_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMIT = DEF_LIMIT
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iInc,
    input  logic             iDec,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iData,
    input  logic             iSat,
    output logic [WIDTH-1:0] oCount,
    output logic             oAtMax,
    output logic             oAtMin,
    output logic             oOvf,
    output logic             oUnf
);

    localparam logic [WIDTH-1:0] LIM  = LIMIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;

    op_e              w_op;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic             w_at_max;
    logic             w_at_min;

    // Limits are compared against LIMIT, not the all-ones value, so the
    // +1/-1 below never carries or borrows out of the register.
    assign w_at_max = (r_count == LIM);
    assign w_at_min = (r_count == ZERO);

    always_comb begin
        w_op        = OP_HOLD;
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;

        // Load beats pulses; simultaneous inc+dec cancel out to a hold.
        if (iLoad)
            w_op = OP_LOAD;
        else if (iInc && !iDec)
            w_op = OP_INC;
        else if (iDec && !iInc)
            w_op = OP_DEC;

        case (w_op)
            OP_LOAD: begin
                w_count_nxt = (iData > LIM) ? LIM : iData;
            end
            OP_INC: begin
                if (w_at_max) begin
                    w_ovf_nxt   = 1'b1;
                    w_count_nxt = (iSat == MODE_SAT) ? LIM : ZERO;
                end else begin
                    w_count_nxt = r_count + ONE;
                end
            end
            OP_DEC: begin
                if (w_at_min) begin
                    w_unf_nxt   = 1'b1;
                    w_count_nxt = (iSat == MODE_SAT) ? ZERO : LIM;
                end else begin
                    w_count_nxt = r_count - ONE;
                end
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_count <= ZERO;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    assign oCount = r_count;
    assign oAtMax = w_at_max;
    assign oAtMin = w_at_min;
    assign oOvf   = r_ovf;
    assign oUnf   = r_unf;

endmodule : contador_ud_pulsos

// File: tb/tb_contador_ud_pulsos.sv
// -----------------------------------------------------------------------------
// tb_contador_ud_pulsos
// Two counters share one stimulus stream: one with LIMIT=9, one with the
// default LIMIT=255. The driver applies inputs on the falling edge and pushes
// the reference model's expected post-edge state into a queue; the monitor
// pops one entry after every rising edge and compares both counters.
// -----------------------------------------------------------------------------
module tb_contador_ud_pulsos;

    localparam int W    = 8;
    localparam int LIM0 = 9;
    localparam int LIM1 = 255;

    logic         iClk = 1'b0;
    logic         iReset, iInc, iDec, iLoad, iSat;
    logic [W-1:0] iData;

    logic [W-1:0] cnt0, cnt1;
    logic         amax0, amin0, ovf0, unf0;
    logic         amax1, amin1, ovf1, unf1;

    always #5 iClk = ~iClk;

    contador_ud_pulsos #(.WIDTH(W), .LIMIT(LIM0)) u_dut9 (
        .iClk(iClk), .iReset(iReset), .iInc(iInc), .iDec(iDec),
        .iLoad(iLoad), .iData(iData), .iSat(iSat),
        .oCount(cnt0), .oAtMax(amax0), .oAtMin(amin0), .oOvf(ovf0), .oUnf(unf0)
    );

    contador_ud_pulsos #(.WIDTH(W), .LIMIT(LIM1)) u_dut255 (
        .iClk(iClk), .iReset(iReset), .iInc(iInc), .iDec(iDec),
        .iLoad(iLoad), .iData(iData), .iSat(iSat),
        .oCount(cnt1), .oAtMax(amax1), .oAtMin(amin1), .oOvf(ovf1), .oUnf(unf1)
    );

    typedef struct {
        int c0;
        int c1;
        bit o0;
        bit o1;
        bit u0;
        bit u1;
        bit tag;
        int idx;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int mc0 = 0;
    int mc1 = 0;

    // bookkeeping for the 256-pulse run on the LIMIT=255 counter
    bit cur_tag = 1'b0;
    int cur_idx = 0;
    int ovf_seen = 0;
    int ovf_at = -1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: one rising edge of a counter spanning 0..lim.
    function automatic void ref_step(input int lim, input int c,
                                     input bit rst, input bit ld, input bit inc,
                                     input bit dec, input bit sat, input int data,
                                     output int nc, output bit ov, output bit un);
        nc = c;
        ov = 1'b0;
        un = 1'b0;
        if (rst) begin
            nc = 0;
        end else if (ld) begin
            nc = (data > lim) ? lim : data;
        end else if (inc && !dec) begin
            if (c == lim) begin
                ov = 1'b1;
                nc = sat ? lim : 0;
            end else begin
                nc = c + 1;
            end
        end else if (dec && !inc) begin
            if (c == 0) begin
                un = 1'b1;
                nc = sat ? 0 : lim;
            end else begin
                nc = c - 1;
            end
        end
    endfunction

    task automatic step(input bit rst, input bit ld, input bit inc, input bit dec,
                        input bit sat, input int data);
        exp_t e;
        @(negedge iClk);
        iReset = rst;
        iLoad  = ld;
        iInc   = inc;
        iDec   = dec;
        iSat   = sat;
        iData  = W'(data);
        ref_step(LIM0, mc0, rst, ld, inc, dec, sat, data, e.c0, e.o0, e.u0);
        ref_step(LIM1, mc1, rst, ld, inc, dec, sat, data, e.c1, e.o1, e.u1);
        mc0   = e.c0;
        mc1   = e.c1;
        e.tag = cur_tag;
        e.idx = cur_idx;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge iClk);
            #2;
            n++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge iClk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("cnt9",   int'(cnt0),  e.c0);
                check("ovf9",   int'(ovf0),  int'(e.o0));
                check("unf9",   int'(unf0),  int'(e.u0));
                check("atmax9", int'(amax0), int'(e.c0 == LIM0));
                check("atmin9", int'(amin0), int'(e.c0 == 0));
                check("cnt255",   int'(cnt1),  e.c1);
                check("ovf255",   int'(ovf1),  int'(e.o1));
                check("unf255",   int'(unf1),  int'(e.u1));
                check("atmax255", int'(amax1), int'(e.c1 == LIM1));
                check("atmin255", int'(amin1), int'(e.c1 == 0));
                if (e.tag && ovf1 === 1'b1) begin
                    ovf_seen++;
                    ovf_at = e.idx;
                end
            end
        end
    end

    // driver
    initial begin
        iReset = 1'b1;
        iInc   = 1'b0;
        iDec   = 1'b0;
        iLoad  = 1'b0;
        iSat   = 1'b0;
        iData  = '0;

        // reset, then three increments
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // wrap overflow on the LIMIT=9 counter
        step(0, 1, 0, 0, 0, 9);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // saturating underflow, back-to-back
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // wrap underflow, then inc+dec together, then clamped load
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 5);
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0, 200);
        step(0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);

        // load beats inc, reset beats inc
        step(0, 1, 0, 0, 0, 7);
        step(0, 1, 1, 0, 0, 2);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // 256 increments from 0 with the default limit
        step(1, 0, 0, 0, 0, 0);
        cur_tag = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            cur_idx = i;
            step(0, 0, 1, 0, 0, 0);
        end
        cur_tag = 1'b0;
        cur_idx = 0;
        step(0, 0, 0, 0, 0, 0);
        drain();
        check("ovf255_strobe_count", ovf_seen, 1);
        check("ovf255_strobe_pulse", ovf_at, 256);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            bit rst, ld, inc, dec;
            r   = int'($urandom_range(0, 99));
            rst = (r < 2);
            ld  = (r >= 2 && r < 12);
            inc = ($urandom_range(0, 99) < 45);
            dec = ($urandom_range(0, 99) < 45);
            step(rst, ld, inc, dec, bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        end
        step(0, 0, 0, 0, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_contador_ud_pulsos
